// File: rtl/calib_burst_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : calib_pkg
//  Purpose  : Shared definitions for the calibration burst packer: FSM state
//             encoding and elaboration-time helper functions for byte count,
//             index width and parameter legality.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package calib_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARM        = 3'd1,
    ST_WAIT       = 3'd2,
    ST_SER        = 3'd3,
    ST_SWAP       = 3'd4,
    ST_CLOSE_PART = 3'd5
  } calib_state_e;

  // Number of bytes in one edge-data word.
  function automatic int calib_bytes(input int data_w);
    return data_w / 8;
  endfunction

  // Byte-index width; a single-byte word still gets a 1-bit index held at 0.
  function automatic int calib_idx_w(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

  function automatic bit calib_width_ok(input int data_w);
    return (data_w >= 8) && ((data_w % 8) == 0);
  endfunction

  function automatic bit calib_addr_fits(input int pkt_points, input int bytes,
                                         input int addr_w);
    return (longint'(pkt_points) * longint'(bytes)) <= (longint'(1) << addr_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/calib_byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : calib_byte_serializer
//  Purpose  : Loads one DATA_W-bit word and presents it one byte per clock,
//             MSB-first or LSB-first.
//  Ports    : i_clk, i_rst_n   clock, asynchronous active-low reset
//             i_load           capture i_data and start emitting
//             i_abort          drop the word in flight (wins over i_load)
//             i_data           word to serialise
//             o_byte           current byte
//             o_valid          o_byte is a live byte this cycle
//             o_last           o_byte is the final byte of the word
//  Revision : 1.0  initial release
// ============================================================================
module calib_byte_serializer
  import calib_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_data,
  output logic [7:0]        o_byte,
  output logic              o_valid,
  output logic              o_last
);

  localparam int             BYTES    = calib_bytes(DATA_W);
  localparam int             IDX_W    = calib_idx_w(BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] shift_next;
  logic              at_last;

  // The outgoing byte always sits at the same end of the shift register;
  // the register moves toward that end after each byte.
  if (MSB_FIRST) begin : g_msb_first
    assign o_byte     = shift_q[DATA_W-1 -: 8];
    assign shift_next = shift_q << 8;
  end else begin : g_lsb_first
    assign o_byte     = shift_q[7:0];
    assign shift_next = shift_q >> 8;
  end

  // For a one-byte word LAST_IDX is 0 and idx_q never leaves 0.
  assign at_last = (idx_q == LAST_IDX);
  assign o_valid = valid_q;
  assign o_last  = valid_q & at_last;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (i_abort) begin
      valid_d = 1'b0;
      idx_d   = '0;
    end else if (i_load) begin
      shift_d = i_data;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q) begin
      shift_d = shift_next;
      if (at_last) begin
        valid_d = 1'b0;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/calib_burst_packer.sv
`default_nettype none
// ============================================================================
//  Module   : calib_burst_packer
//  Purpose  : Captures edge-data words inside an armed angular window and
//             writes them byte-by-byte into a ping-pong calibration RAM,
//             closing a half when it is full or when the stop angle is hit.
//  Ports    : i_clk_50m, i_rst_n      clock, asynchronous active-low reset
//             i_measure_en            gates o_calib_make
//             i_code_angle            encoder angle
//             i_edge_data             shot data, valid with i_dist_new_sig
//             i_dist_new_sig          one-cycle new-shot strobe
//             i_start_index/stop      window bounds
//             i_calibrate_flag        calibration enable (level)
//             o_calib_wren/wrdata/wraddr  RAM write port
//             o_calib_pingpang        half being written
//             o_calib_points          points in the half just closed
//             o_calib_make            buffer-ready pulse
//             o_calib_overrun         shot dropped pulse
//             o_calib_busy            capturing or serialising
//  Revision : 1.0  initial release
// ============================================================================
module calib_burst_packer
  import calib_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int PKT_POINTS = 64,
  parameter int ADDR_W     = 10,
  parameter int ANGLE_W    = 16,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic               i_clk_50m,
  input  logic               i_rst_n,
  input  logic               i_measure_en,
  input  logic [ANGLE_W-1:0] i_code_angle,
  input  logic [DATA_W-1:0]  i_edge_data,
  input  logic               i_dist_new_sig,
  input  logic [ANGLE_W-1:0] i_start_index,
  input  logic [ANGLE_W-1:0] i_stop_index,
  input  logic               i_calibrate_flag,
  output logic               o_calib_wren,
  output logic [7:0]         o_calib_wrdata,
  output logic [ADDR_W-1:0]  o_calib_wraddr,
  output logic               o_calib_pingpang,
  output logic [15:0]        o_calib_points,
  output logic               o_calib_make,
  output logic               o_calib_overrun,
  output logic               o_calib_busy
);

  localparam int BYTES  = calib_bytes(DATA_W);
  localparam int PCNT_W = $clog2(PKT_POINTS + 1);
  localparam logic [PCNT_W-1:0] PKT_CNT = PCNT_W'(PKT_POINTS);

  if (!calib_width_ok(DATA_W)) begin : g_chk_data_w
    $error("calib_burst_packer: DATA_W must be a positive multiple of 8");
  end
  if (PKT_POINTS < 1) begin : g_chk_pkt_points
    $error("calib_burst_packer: PKT_POINTS must be at least 1");
  end
  if (!calib_addr_fits(PKT_POINTS, BYTES, ADDR_W)) begin : g_chk_addr_fit
    $error("calib_burst_packer: PKT_POINTS*BYTES does not fit in ADDR_W");
  end

  calib_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              pingpang_q, pingpang_d;
  logic [15:0]       points_q, points_d;
  logic              make_q, make_d;
  logic              overrun_q, overrun_d;

  logic              ser_load;
  logic              ser_abort;
  logic              ser_valid;
  logic              ser_last;
  logic [7:0]        ser_byte;

  calib_byte_serializer #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_ser (
    .i_clk   (i_clk_50m),
    .i_rst_n (i_rst_n),
    .i_load  (ser_load),
    .i_abort (ser_abort),
    .i_data  (i_edge_data),
    .o_byte  (ser_byte),
    .o_valid (ser_valid),
    .o_last  (ser_last)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pcnt_d     = pcnt_q;
    pingpang_d = pingpang_q;
    points_d   = points_q;
    make_d     = 1'b0;
    ser_load   = 1'b0;
    ser_abort  = 1'b0;
    // A strobe while bytes are still going out cannot be captured.
    overrun_d  = i_dist_new_sig && (state_q == ST_SER);

    unique case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        pcnt_d = '0;
        if (i_code_angle == ANGLE_W'(1)) begin
          state_d = ST_ARM;
        end
      end

      ST_ARM: begin
        if (i_calibrate_flag && (i_code_angle == i_start_index)) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (!i_calibrate_flag) begin
          addr_d  = '0;
          pcnt_d  = '0;
          state_d = ST_IDLE;
        end else if (i_dist_new_sig) begin
          ser_load = 1'b1;
          pcnt_d   = pcnt_q + PCNT_W'(1);
          state_d  = ST_SER;
        end
      end

      ST_SER: begin
        if (!i_calibrate_flag) begin
          // Abandon the half in progress; the next run restarts at 0.
          ser_abort = 1'b1;
          addr_d    = '0;
          pcnt_d    = '0;
          state_d   = ST_IDLE;
        end else if (ser_valid) begin
          addr_d = addr_q + ADDR_W'(1);
          if (ser_last) begin
            if (i_code_angle >= i_stop_index) begin
              state_d = ST_CLOSE_PART;
            end else if (pcnt_q == PKT_CNT) begin
              state_d = ST_SWAP;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
      end

      ST_SWAP: begin
        points_d   = 16'(PKT_POINTS);
        pingpang_d = ~pingpang_q;
        make_d     = 1'b1;
        addr_d     = '0;
        pcnt_d     = '0;
        state_d    = ST_WAIT;
      end

      ST_CLOSE_PART: begin
        if (pcnt_q != '0) begin
          points_d   = 16'(pcnt_q);
          pingpang_d = ~pingpang_q;
          make_d     = 1'b1;
        end
        addr_d  = '0;
        pcnt_d  = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      pcnt_q     <= '0;
      pingpang_q <= 1'b0;
      points_q   <= '0;
      make_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pcnt_q     <= pcnt_d;
      pingpang_q <= pingpang_d;
      points_q   <= points_d;
      make_q     <= make_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_calib_wren     = (state_q == ST_SER) && ser_valid;
  assign o_calib_wrdata   = ser_byte;
  assign o_calib_wraddr   = addr_q;
  assign o_calib_pingpang = pingpang_q;
  assign o_calib_points   = points_q;
  assign o_calib_make     = i_measure_en & make_q;
  assign o_calib_overrun  = overrun_q;
  assign o_calib_busy     = (state_q == ST_WAIT) || (state_q == ST_SER);

endmodule
`default_nettype wire

// File: doc/calib_burst_packer.md
Name: calib_burst_packer

Overview:
- Parametrised successor to the calibration packetiser.
- Within an armed angular window [i_start_index, i_stop_index], captures one DATA_W-bit edge-data word per i_dist_new_sig.
- Serialises each word into bytes, one byte per clock, into a ping-pong calibration RAM.
- Signals completion of each buffer half to the upload path with a point count.
- New over the previous generation: configurable word width, depth and byte order; partial-buffer close at the stop angle with no waiting for padding shots; overrun flag; busy flag.

Parameters:
- DATA_W, 64: edge-data bits per point; must be a multiple of 8. BYTES = DATA_W/8.
- PKT_POINTS, 64: points per buffer half; must be at least 1.
- ADDR_W, 10: write-address width; PKT_POINTS*BYTES must be <= 2**ADDR_W.
- ANGLE_W, 16: encoder angle and index width.
- MSB_FIRST, 1: 1 writes byte [DATA_W-1:DATA_W-8] first; 0 writes byte [7:0] first.

Ports:
- i_clk_50m  in  1  system clock.
- i_rst_n  in  1  reset; asynchronous, active-low. One clock domain only.
- i_measure_en  in  1  gates o_calib_make.
- i_code_angle  in  ANGLE_W  current encoder angle.
- i_edge_data  in  DATA_W  edge data for the current shot; valid with i_dist_new_sig.
- i_dist_new_sig  in  1  one-cycle new-shot strobe.
- i_start_index  in  ANGLE_W  window start angle.
- i_stop_index  in  ANGLE_W  window stop angle.
- i_calibrate_flag  in  1  calibration enable, level.
- o_calib_wren  out  1  RAM write enable.
- o_calib_wrdata  out  8  RAM write byte.
- o_calib_wraddr  out  ADDR_W  RAM address within the current half.
- o_calib_pingpang  out  1  half currently being written.
- o_calib_points  out  16  points in the half just closed.
- o_calib_make  out  1  one-cycle buffer-ready pulse, ANDed with i_measure_en.
- o_calib_overrun  out  1  one-cycle pulse when a shot is dropped.
- o_calib_busy  out  1  high in WAIT or SER.

Behaviour:
- Reset: all outputs and internal registers are 0; state is IDLE.
- State IDLE
  - Go to ARM when i_code_angle == 1 (revolution origin).
  - Write address, point count and byte count are held at 0.
- State ARM
  - Go to WAIT when i_calibrate_flag && i_code_angle == i_start_index.
- State WAIT
  - On i_dist_new_sig: capture i_edge_data into the shift register, increment the point count, go to SER.
- State SER
  - Emits BYTES consecutive writes, one per clock.
  - For a capture at edge t: o_calib_wren is high on cycles t+1 .. t+BYTES.
  - o_calib_wraddr = point_index*BYTES + byte_index, where point_index counts from 0 within the half.
  - After the last byte, decide in priority order:
    1. i_code_angle >= i_stop_index -> CLOSE_PART.
    2. Point count == PKT_POINTS -> SWAP.
    3. Otherwise -> WAIT.
- State SWAP (one cycle)
  - o_calib_points <= PKT_POINTS.
  - Toggle o_calib_pingpang.
  - Pulse make.
  - Clear address and point count.
  - Go to WAIT.
- State CLOSE_PART (one cycle)
  - If point count > 0: o_calib_points <= count, toggle pingpang, pulse make.
  - If point count == 0: no make and no toggle.
  - Go to IDLE.
- Abort: i_calibrate_flag low in WAIT or SER -> IDLE next cycle.
  - wren drops immediately.
  - No make and no toggle.
  - The partially written half is discarded; the next run overwrites it from address 0.
- Overrun: an i_dist_new_sig during SER is not captured.
  - o_calib_overrun pulses the next cycle.
  - Point count is unchanged.
  - Minimum shot spacing is therefore BYTES+1 clocks.
- Simultaneous last-byte and new_sig: counts as an overrun; the transition still follows the normal rules.
- Window with i_stop_index <= i_start_index: the window closes after the first point (no angle wrap-around support).
- o_calib_make = i_measure_en & make_reg. o_calib_points and o_calib_pingpang update on the make cycle and hold until the next close.
- Counter widths:
  - Point count: clog2(PKT_POINTS+1) bits.
  - Byte index: clog2(BYTES) bits; for BYTES == 1 use a 1-bit index fixed at 0.
  - o_calib_points is zero-extended to 16 bits.

Decomposition:
- Package calib_pkg:
  - State encoding: IDLE, ARM, WAIT, SER, SWAP, CLOSE_PART.
  - Function for BYTES.
  - Elaboration-time checks on the DATA_W multiple and on the address fit.
- Sub-module calib_byte_serializer:
  - Contents: load strobe, shift register, byte counter, MSB_FIRST select.
  - Outputs: byte, valid, last.
  - The top module keeps the FSM, address, point count, ping-pong and make logic.

Test Plan:
- Defaults; start=100, stop=2000; 64 shots spaced 20 clocks, first data 0x0102030405060708.
  - Writes are 01..08 at addresses 0..7, each wren one clock.
  - After shot 64: make pulses, points=64, pingpang 0->1, next shot writes address 0.
- MSB_FIRST=0, DATA_W=32; data 0xAABBCCDD.
  - Bytes DD, CC, BB, AA at addresses 0..3 on cycles t+1..t+4.
- Angle reaches stop after 10 shots.
  - One make, points=10, pingpang toggles, state returns to IDLE.
  - Repeat with stop reached before any shot: no make, no toggle.
- i_calibrate_flag dropped mid-SER on point 5.
  - wren low the next cycle, no make, pingpang unchanged.
  - Re-arming writes from address 0.
- new_sig 3 clocks after the previous one (BYTES=8).
  - o_calib_overrun pulses once.
  - Point count is not incremented.
  - Address sequence continues without a gap.
- i_measure_en=0 during a SWAP.
  - o_calib_make stays 0.
  - pingpang still toggles and points=64.
  - Asserting i_rst_n low mid-SER clears all outputs asynchronously.
